// File: rtl/punc_ctrl_mc_if.sv
// Control bus between the PUnC multi-cycle controller and the datapath/memory side.
// master: the controller (drives strobes and status, samples ir/nzp_match/mem_rdy/step).
// slave:  the datapath/memory side.
interface punc_ctrl_mc_if #(
   parameter int CNT_W = 32
);
   logic [15:0]      ir;
   logic             nzp_match;
   logic             mem_rdy;
   logic             step;
   logic [1:0]       ir_ctl;
   logic [4:0]       pc_ctl;
   logic [5:0]       mem_ctl;
   logic [6:0]       rf_ctl;
   logic [5:0]       dp_ctl;
   logic             halted;
   logic             err;
   logic [1:0]       err_code;
   logic [CNT_W-1:0] instret;

   modport master (
      input  ir, nzp_match, mem_rdy, step,
      output ir_ctl, pc_ctl, mem_ctl, rf_ctl, dp_ctl, halted, err, err_code, instret
   );

   modport slave (
      output ir, nzp_match, mem_rdy, step,
      input  ir_ctl, pc_ctl, mem_ctl, rf_ctl, dp_ctl, halted, err, err_code, instret
   );
endinterface

// File: rtl/punc_ctrl_mc.sv
// PUnC LC3 multi-cycle control FSM with a mem_rdy handshake, access timeout,
// sticky error trap and retired-instruction counter.
// Optional feature: define PUNC_STEP_EN to stall at every instruction boundary
// in STEP_WAIT until a step pulse arrives.
// Select encodings:
//   pc_sel    0 PC+off9, 1 PC+off11, 2 Rq
//   raddr_sel 0 PC, 1 PC+off9, 2 Rq+off6, 3 temp
//   waddr_sel 0 PC+off9, 1 Rq+off6, 2 temp          (memory write address)
//   wdata_sel 0 ALU, 1 memory, 2 PC+off9, 3 PC
//   rf waddr  0 ir[11:9], 1 R7;  rp_sel 0 ir[2:0], 1 ir[11:9];  Rq is ir[8:6]
//   alu_sel   0 ADD, 1 AND, 2 NOT_B;  alu_a_sel 0 Rp, 1 imm5
module punc_ctrl_mc #(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32
) (
   input logic           clk,
   input logic           rst,
   punc_ctrl_mc_if.master bus
);
   localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

   localparam logic [3:0] OP_BR = 4'd0,  OP_ADD = 4'd1,  OP_LD  = 4'd2,  OP_ST  = 4'd3;
   localparam logic [3:0] OP_JSR = 4'd4, OP_AND = 4'd5,  OP_LDR = 4'd6,  OP_STR = 4'd7;
   localparam logic [3:0] OP_NOT = 4'd9, OP_LDI = 4'd10, OP_STI = 4'd11, OP_JMP = 4'd12;
   localparam logic [3:0] OP_LEA = 4'd14, OP_HLT = 4'd15;

   localparam logic [1:0] PS_OFF9 = 2'd0, PS_OFF11 = 2'd1, PS_RQ = 2'd2;
   localparam logic [1:0] RA_PC = 2'd0, RA_OFF9 = 2'd1, RA_BASE = 2'd2, RA_TEMP = 2'd3;
   localparam logic [1:0] WA_OFF9 = 2'd0, WA_BASE = 2'd1, WA_TEMP = 2'd2;
   localparam logic [1:0] WD_ALU = 2'd0, WD_MEM = 2'd1, WD_PCOFF = 2'd2, WD_PC = 2'd3;
   localparam logic [1:0] ALU_ADD = 2'd0, ALU_AND = 2'd1, ALU_NOT = 2'd2;
   localparam logic [1:0] EC_NONE = 2'd0, EC_ILLEGAL = 2'd1, EC_TIMEOUT = 2'd2;

   typedef enum logic [2:0] {
      INIT, FETCH, DECODE, EXEC, EXEC2, HALT, ERR
`ifdef PUNC_STEP_EN
      , STEP_WAIT
`endif
   } state_t;

   state_t            state_q, state_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic [CNT_W-1:0]  instret_q, instret_d;
   logic [1:0]        err_code_q, err_code_d;

   logic       ir_clr, ir_ld, pc_clr, pc_inc, pc_ld, mem_rd, mem_wr;
   logic [1:0] pc_sel, raddr_sel, mwaddr_sel, wdata_sel, alu_sel;
   logic       rf_wr, rf_waddr_sel, rp_sel, rp_rd, rq_rd;
   logic       temp_ld, nzp_ld, nzp_clr, alu_a_sel;
   logic       mem_busy, done, boundary;
   logic [3:0] opcode;
   logic       rdy;
   logic       unused_bits;

   assign opcode      = bus.ir[15:12];
   assign rdy         = bus.mem_rdy;
   assign unused_bits = ^{bus.ir[10:6], bus.ir[4:0], bus.step};

   // Next state, counters and all control strobes from state/ir/nzp_match/mem_rdy
   always_comb begin
      state_d = state_q;  wait_d = '0;  instret_d = instret_q;  err_code_d = err_code_q;
      ir_clr = 1'b0;  ir_ld = 1'b0;  pc_clr = 1'b0;  pc_inc = 1'b0;  pc_ld = 1'b0;  pc_sel = PS_OFF9;
      mem_rd = 1'b0;  mem_wr = 1'b0;  raddr_sel = RA_PC;  mwaddr_sel = WA_OFF9;
      rf_wr = 1'b0;  wdata_sel = WD_ALU;  rf_waddr_sel = 1'b0;  rp_sel = 1'b0;  rp_rd = 1'b0;  rq_rd = 1'b0;
      temp_ld = 1'b0;  nzp_ld = 1'b0;  nzp_clr = 1'b0;  alu_sel = ALU_ADD;  alu_a_sel = 1'b0;
      mem_busy = 1'b0;  done = 1'b0;  boundary = 1'b0;
      case (state_q)
         INIT: begin
            ir_clr = 1'b1;  pc_clr = 1'b1;  nzp_clr = 1'b1;  boundary = 1'b1;
         end
         FETCH: begin
            mem_rd = 1'b1;  raddr_sel = RA_PC;  mem_busy = 1'b1;
            if (rdy) begin ir_ld = 1'b1;  pc_inc = 1'b1;  state_d = DECODE; end
         end
         DECODE: state_d = EXEC;
         EXEC: begin
            case (opcode)
               OP_ADD, OP_AND: begin
                  rf_wr = 1'b1;  wdata_sel = WD_ALU;  rp_rd = 1'b1;  rq_rd = 1'b1;
                  alu_sel = (opcode == OP_AND) ? ALU_AND : ALU_ADD;
                  alu_a_sel = bus.ir[5];  nzp_ld = 1'b1;  done = 1'b1;
               end
               OP_NOT: begin
                  rf_wr = 1'b1;  wdata_sel = WD_ALU;  rq_rd = 1'b1;  alu_sel = ALU_NOT;
                  nzp_ld = 1'b1;  done = 1'b1;
               end
               OP_LEA: begin rf_wr = 1'b1;  wdata_sel = WD_PCOFF;  nzp_ld = 1'b1;  done = 1'b1; end
               OP_BR:  begin pc_ld = bus.nzp_match;  pc_sel = PS_OFF9;  done = 1'b1; end
               OP_JMP: begin pc_ld = 1'b1;  pc_sel = PS_RQ;  rq_rd = 1'b1;  done = 1'b1; end
               OP_LD, OP_LDR: begin
                  mem_rd = 1'b1;  mem_busy = 1'b1;
                  raddr_sel = (opcode == OP_LDR) ? RA_BASE : RA_OFF9;
                  rq_rd = (opcode == OP_LDR);
                  if (rdy) begin rf_wr = 1'b1;  wdata_sel = WD_MEM;  nzp_ld = 1'b1;  done = 1'b1; end
               end
               OP_ST, OP_STR: begin
                  mem_wr = 1'b1;  mem_busy = 1'b1;  rp_sel = 1'b1;  rp_rd = 1'b1;
                  mwaddr_sel = (opcode == OP_STR) ? WA_BASE : WA_OFF9;
                  rq_rd = (opcode == OP_STR);
                  done = rdy;
               end
               OP_LDI, OP_STI: begin
                  mem_rd = 1'b1;  raddr_sel = RA_OFF9;  mem_busy = 1'b1;
                  if (rdy) begin temp_ld = 1'b1;  state_d = EXEC2; end
               end
               OP_JSR: begin
                  rf_wr = 1'b1;  wdata_sel = WD_PC;  rf_waddr_sel = 1'b1;  state_d = EXEC2;
               end
               OP_HLT: begin state_d = HALT;  instret_d = instret_q + 1'b1; end
               default: begin state_d = ERR;  err_code_d = EC_ILLEGAL; end
            endcase
         end
         EXEC2: begin
            case (opcode)
               OP_JSR: begin
                  pc_ld = 1'b1;  pc_sel = bus.ir[11] ? PS_OFF11 : PS_RQ;
                  rq_rd = ~bus.ir[11];  done = 1'b1;
               end
               OP_LDI: begin
                  mem_rd = 1'b1;  raddr_sel = RA_TEMP;  mem_busy = 1'b1;
                  if (rdy) begin rf_wr = 1'b1;  wdata_sel = WD_MEM;  nzp_ld = 1'b1;  done = 1'b1; end
               end
               default: begin
                  mem_wr = 1'b1;  mwaddr_sel = WA_TEMP;  rp_sel = 1'b1;  rp_rd = 1'b1;
                  mem_busy = 1'b1;  done = rdy;
               end
            endcase
         end
`ifdef PUNC_STEP_EN
         STEP_WAIT: if (bus.step) state_d = FETCH;
`endif
         default: ;
      endcase
      // Completed instruction: retire it and cross the instruction boundary
      if (done) begin
         boundary  = 1'b1;
         instret_d = instret_q + 1'b1;
      end
      if (boundary) begin
`ifdef PUNC_STEP_EN
         state_d = STEP_WAIT;
`else
         state_d = FETCH;
`endif
      end
      // Stalled access: count waiting cycles; a ready in the last allowed cycle still completes
      if (mem_busy && !rdy) begin
         if (wait_q == WAIT_W'(MEM_TIMEOUT - 1)) begin
            state_d    = ERR;
            err_code_d = EC_TIMEOUT;
         end else begin
            wait_d = wait_q + 1'b1;
         end
      end
   end

   // Control state registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= INIT;
         wait_q     <= '0;
         instret_q  <= '0;
         err_code_q <= EC_NONE;
      end else begin
         state_q    <= state_d;
         wait_q     <= wait_d;
         instret_q  <= instret_d;
         err_code_q <= err_code_d;
      end
   end

   assign bus.ir_ctl   = {ir_clr, ir_ld};
   assign bus.pc_ctl   = {pc_clr, pc_inc, pc_ld, pc_sel};
   assign bus.mem_ctl  = {mem_rd, mem_wr, raddr_sel, mwaddr_sel};
   assign bus.rf_ctl   = {rf_wr, wdata_sel, rf_waddr_sel, rp_sel, rp_rd, rq_rd};
   assign bus.dp_ctl   = {temp_ld, nzp_ld, nzp_clr, alu_sel, alu_a_sel};
   assign bus.halted   = (state_q == HALT);
   assign bus.err      = (state_q == ERR);
   assign bus.err_code = err_code_q;
   assign bus.instret  = instret_q;
endmodule
